// File: rtl/mag_window_stats.sv
// mag_window_stats
//   Windowed statistics on an 8-bit magnitude stream. A window holds
//   2^WINDOW_LOG2 accepted samples. When a window closes, the block latches
//   the truncated average, the maximum and the minimum, and updates a
//   hysteresis threshold alarm. The alarm has a saturating count of rising
//   events. After each window there is one REPORT cycle in which no sample
//   is accepted.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   i_ena           global enable (freezes all state except sync clear)
//   i_sync_clr      synchronous clear of the partial window, forces ACCUM
//   i_in_valid      sample present on i_in_mag
//   i_in_mag        unsigned magnitude sample
//   o_in_ready      high in ACCUM, low in REPORT
//   i_thresh        alarm threshold, sampled at window close
//   o_out_valid     high while in REPORT
//   o_out_avg/max/min  statistics of the last closed window
//   o_alarm         hysteresis alarm level
//   o_alarm_count   alarm rising events, saturating at 255
module mag_window_stats #(
   parameter int WINDOW_LOG2 = 3,
   parameter int HYST        = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_ena,
   input  logic       i_sync_clr,
   input  logic       i_in_valid,
   input  logic [7:0] i_in_mag,
   output logic       o_in_ready,
   input  logic [7:0] i_thresh,
   output logic       o_out_valid,
   output logic [7:0] o_out_avg,
   output logic [7:0] o_out_max,
   output logic [7:0] o_out_min,
   output logic       o_alarm,
   output logic [7:0] o_alarm_count
);

   localparam int         SW    = 8 + WINDOW_LOG2;
   localparam logic [8:0] HYST9 = 9'(HYST);

   typedef enum logic {ST_ACCUM = 1'b0, ST_REPORT = 1'b1} state_t;

   state_t                 r_state, w_state_nxt;
   logic [SW-1:0]          r_sum;
   logic [7:0]             r_max, r_min;
   logic [WINDOW_LOG2-1:0] r_cnt;
   logic [7:0]             r_avg_o, r_max_o, r_min_o;
   logic                   r_alarm;
   logic [7:0]             r_alarm_cnt;

   logic                   w_accept, w_close;
   logic [SW-1:0]          w_sum_nxt;
   logic [7:0]             w_max_nxt, w_min_nxt, w_avg_nxt;
   logic                   w_rise, w_fall;

   // A sample colliding with sync_clr is dropped, so it never counts as accepted.
   assign w_accept  = i_ena & i_in_valid & ~i_sync_clr & (r_state == ST_ACCUM);
   assign w_close   = w_accept & (r_cnt == '1);

   // Next-window values include the sample being accepted; at close they
   // are latched directly into the outputs.
   assign w_sum_nxt = r_sum + SW'(i_in_mag);
   assign w_max_nxt = (i_in_mag > r_max) ? i_in_mag : r_max;
   assign w_min_nxt = (i_in_mag < r_min) ? i_in_mag : r_min;
   assign w_avg_nxt = w_sum_nxt[SW-1:WINDOW_LOG2];

   // 9-bit compares so that avg+HYST cannot wrap.
   assign w_rise = ~r_alarm & ({1'b0, w_avg_nxt} >= {1'b0, i_thresh});
   assign w_fall =  r_alarm & (({1'b0, w_avg_nxt} + HYST9) < {1'b0, i_thresh});

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_ACCUM;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (i_sync_clr) begin
         w_state_nxt = ST_ACCUM;
      end else if (i_ena) begin
         case (r_state)
            ST_ACCUM:  if (w_close) w_state_nxt = ST_REPORT;
            ST_REPORT: w_state_nxt = ST_ACCUM;
            default:   w_state_nxt = ST_ACCUM;
         endcase
      end
   end

   // Accumulators and latched results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum       <= '0;
         r_max       <= 8'd0;
         r_min       <= 8'd255;
         r_cnt       <= '0;
         r_avg_o     <= 8'd0;
         r_max_o     <= 8'd0;
         r_min_o     <= 8'd0;
         r_alarm     <= 1'b0;
         r_alarm_cnt <= 8'd0;
      end else if (i_sync_clr) begin
         r_sum <= '0;
         r_max <= 8'd0;
         r_min <= 8'd255;
         r_cnt <= '0;
      end else if (i_ena) begin
         if (r_state == ST_REPORT) begin
            r_sum <= '0;
            r_max <= 8'd0;
            r_min <= 8'd255;
            r_cnt <= '0;
         end else if (w_accept) begin
            r_sum <= w_sum_nxt;
            r_max <= w_max_nxt;
            r_min <= w_min_nxt;
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_close) begin
            r_avg_o <= w_avg_nxt;
            r_max_o <= w_max_nxt;
            r_min_o <= w_min_nxt;
            if (w_rise) begin
               r_alarm <= 1'b1;
               if (r_alarm_cnt != 8'd255) r_alarm_cnt <= r_alarm_cnt + 8'd1;
            end else if (w_fall) begin
               r_alarm <= 1'b0;
            end
         end
      end
   end

   assign o_in_ready    = (r_state == ST_ACCUM);
   assign o_out_valid   = (r_state == ST_REPORT);
   assign o_out_avg     = r_avg_o;
   assign o_out_max     = r_max_o;
   assign o_out_min     = r_min_o;
   assign o_alarm       = r_alarm;
   assign o_alarm_count = r_alarm_cnt;

endmodule

// File: tb/tb_mag_window_stats.sv
// Directed bench for mag_window_stats (WINDOW_LOG2=3, HYST=4).
module tb_mag_window_stats;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_ena, i_sync_clr, i_in_valid;
   logic [7:0] i_in_mag, i_thresh;
   logic       o_in_ready, o_out_valid, o_alarm;
   logic [7:0] o_out_avg, o_out_max, o_out_min, o_alarm_count;

   int n_tests = 0;
   int n_fail  = 0;

   mag_window_stats #(.WINDOW_LOG2(3), .HYST(4)) dut (
      .clk(clk), .rst_n(rst_n), .i_ena(i_ena), .i_sync_clr(i_sync_clr),
      .i_in_valid(i_in_valid), .i_in_mag(i_in_mag), .o_in_ready(o_in_ready),
      .i_thresh(i_thresh), .o_out_valid(o_out_valid), .o_out_avg(o_out_avg),
      .o_out_max(o_out_max), .o_out_min(o_out_min), .o_alarm(o_alarm),
      .o_alarm_count(o_alarm_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic [7:0] base, step, thresh;
      logic [7:0] e_avg, e_max, e_min;
      logic       e_alarm;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Offer one sample and hold it until accepted; returns 1 ns after the accepting edge.
   task automatic push(input logic [7:0] m);
      int guard = 0;
      i_in_valid = 1'b1;
      i_in_mag   = m;
      while (!(o_in_ready && i_ena)) begin
         @(posedge clk); #1;
         guard++;
         if (guard > 50) begin
            n_tests++; n_fail++;
            $display("FAIL push_timeout: in_ready stuck low");
            break;
         end
      end
      @(posedge clk); #1;
      i_in_valid = 1'b0;
   endtask

   task automatic push_n(input int n, input logic [7:0] m);
      for (int k = 0; k < n; k++) push(m);
   endtask

   task automatic chk_win(input string nm, input int a, input int mx, input int mn);
      chk({nm, "_valid"}, o_out_valid, 1);
      chk({nm, "_avg"},   o_out_avg,   a);
      chk({nm, "_max"},   o_out_max,   mx);
      chk({nm, "_min"},   o_out_min,   mn);
   endtask

   initial begin
      vecs[0] = '{8'd10,  8'd10, 8'd100, 8'd45,  8'd80,  8'd10,  1'b0, 8'd0};
      vecs[1] = '{8'd100, 8'd0,  8'd100, 8'd100, 8'd100, 8'd100, 1'b1, 8'd1};
      vecs[2] = '{8'd97,  8'd0,  8'd100, 8'd97,  8'd97,  8'd97,  1'b1, 8'd1};
      vecs[3] = '{8'd95,  8'd0,  8'd100, 8'd95,  8'd95,  8'd95,  1'b0, 8'd1};
      vecs[4] = '{8'd100, 8'd0,  8'd100, 8'd100, 8'd100, 8'd100, 1'b1, 8'd2};
      vecs[5] = '{8'd0,   8'd30, 8'd100, 8'd105, 8'd210, 8'd0,   1'b1, 8'd2};
      vecs[6] = '{8'd255, 8'd0,  8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 8'd2};
      vecs[7] = '{8'd0,   8'd0,  8'd4,   8'd0,   8'd0,   8'd0,   1'b1, 8'd2};
      vecs[8] = '{8'd0,   8'd0,  8'd5,   8'd0,   8'd0,   8'd0,   1'b0, 8'd2};
      vecs[9] = '{8'd0,   8'd0,  8'd0,   8'd0,   8'd0,   8'd0,   1'b1, 8'd3};

      rst_n = 1'b0; i_ena = 1'b1; i_sync_clr = 1'b0; i_in_valid = 1'b0;
      i_in_mag = 8'd0; i_thresh = 8'd100;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", o_out_valid, 0);
      chk("rst_ready", o_in_ready, 1);
      chk("rst_avg", o_out_avg, 0);
      chk("rst_max", o_out_max, 0);
      chk("rst_min", o_out_min, 0);
      chk("rst_alarm", o_alarm, 0);
      chk("rst_count", o_alarm_count, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back windows: the next window's first sample is held through REPORT.
      for (int v = 0; v < 10; v++) begin
         i_thresh = vecs[v].thresh;
         for (int s = 0; s < 8; s++) push(vecs[v].base + 8'(s) * vecs[v].step);
         chk_win($sformatf("vec%0d", v), vecs[v].e_avg, vecs[v].e_max, vecs[v].e_min);
         chk($sformatf("vec%0d_ready", v), o_in_ready, 0);
         chk($sformatf("vec%0d_alarm", v), o_alarm, vecs[v].e_alarm);
         chk($sformatf("vec%0d_count", v), o_alarm_count, vecs[v].e_cnt);
      end
      @(posedge clk); #1;
      chk("report_one_cycle", o_out_valid, 0);

      // ena low mid-window (sample offered must be ignored) and during REPORT.
      push_n(4, 8'd60);
      i_ena = 1'b0; i_in_valid = 1'b1; i_in_mag = 8'd250;
      repeat (3) begin @(posedge clk); #1; end
      i_ena = 1'b1; i_in_valid = 1'b0;
      push_n(4, 8'd60);
      chk_win("ena_win", 60, 60, 60);
      i_ena = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("ena_stretch%0d", c), o_out_valid, 1);
      end
      i_ena = 1'b1;
      @(posedge clk); #1;
      chk("ena_release", o_out_valid, 0);

      // sync_clr colliding with a sample mid-window.
      push_n(5, 8'd200);
      i_sync_clr = 1'b1; i_in_valid = 1'b1; i_in_mag = 8'd200;
      @(posedge clk); #1;
      i_sync_clr = 1'b0; i_in_valid = 1'b0;
      chk("clr_keeps_avg", o_out_avg, 60);
      push_n(8, 8'd7);
      chk_win("clr_win", 7, 7, 7);
      chk("clr_alarm", o_alarm, 1);
      chk("clr_count", o_alarm_count, 3);

      // sync_clr acts while ena is low.
      push_n(3, 8'd100);
      i_ena = 1'b0; i_sync_clr = 1'b1; i_in_valid = 1'b1; i_in_mag = 8'd100;
      @(posedge clk); #1;
      i_ena = 1'b1; i_sync_clr = 1'b0; i_in_valid = 1'b0;
      push_n(8, 8'd20);
      chk_win("clr_ena_win", 20, 20, 20);

      // sync_clr during REPORT aborts it but keeps latched values.
      push_n(8, 8'd9);
      chk("clr_rep_valid", o_out_valid, 1);
      i_sync_clr = 1'b1;
      @(posedge clk); #1;
      i_sync_clr = 1'b0;
      chk("clr_rep_abort", o_out_valid, 0);
      chk("clr_rep_avg", o_out_avg, 9);
      push_n(8, 8'd30);
      chk_win("clr_rep_next", 30, 30, 30);

      // Reset during REPORT drops out_valid asynchronously.
      @(posedge clk); #1;
      push_n(8, 8'd50);
      rst_n = 1'b0; #1;
      chk("rst_rep_valid", o_out_valid, 0);
      chk("rst_rep_ready", o_in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Rebuild alarm=1 count=3, then reset mid-window.
      i_thresh = 8'd0;  push_n(8, 8'd0);   // rise -> 1
      i_thresh = 8'd5;  push_n(8, 8'd0);   // clear
      i_thresh = 8'd0;  push_n(8, 8'd0);   // rise -> 2
      i_thresh = 8'd5;  push_n(8, 8'd0);   // clear
      i_thresh = 8'd0;  push_n(8, 8'd0);   // rise -> 3
      chk("pre_rst_alarm", o_alarm, 1);
      chk("pre_rst_count", o_alarm_count, 3);
      push_n(4, 8'd50);
      rst_n = 1'b0; #1;
      chk("mid_rst_avg", o_out_avg, 0);
      chk("mid_rst_max", o_out_max, 0);
      chk("mid_rst_min", o_out_min, 0);
      chk("mid_rst_alarm", o_alarm, 0);
      chk("mid_rst_count", o_alarm_count, 0);
      chk("mid_rst_valid", o_out_valid, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      push_n(8, 8'd50);
      chk_win("post_rst_win", 50, 50, 50);
      chk("post_rst_count", o_alarm_count, 1);

      // Alarm count saturation: 260 more rising events.
      for (int p = 0; p < 260; p++) begin
         i_thresh = 8'd5; push_n(8, 8'd0);
         i_thresh = 8'd5; push_n(8, 8'd10);
      end
      chk("sat_alarm", o_alarm, 1);
      chk("sat_count", o_alarm_count, 255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
